// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared definitions for the instruction dispatcher.
//   - FSM state encoding
//   - opcode class encoding and opcode range constants
//   - instruction field bit positions
//   - default watchdog length
//   - classify(): maps a 4-bit opcode to its execution class
package dispatch_pkg;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
   localparam int unsigned INSTR_W = 16;

   // Instruction word layout: [15:12] opcode, [11:6] Ri, [5:0] Rj / immediate
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned RI_MSB  = 11;
   localparam int unsigned RI_LSB  = 6;
   localparam int unsigned RJ_MSB  = 5;
   localparam int unsigned RJ_LSB  = 0;

   localparam logic [3:0] OPC_MOV     = 4'h0;
   localparam logic [3:0] OPC_MOVI    = 4'h1;
   localparam logic [3:0] OPC_ALU_LO  = 4'h2;
   localparam logic [3:0] OPC_ALU_HI  = 4'h7;
   localparam logic [3:0] OPC_ALUI_LO = 4'hA;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ISSUE,
      S_WAIT,
      S_RETIRE
   } state_t;

   typedef enum logic [2:0] {
      CLS_MOV,
      CLS_MOVI,
      CLS_ALU,
      CLS_ALUI,
      CLS_ILLEGAL
   } op_class_t;

   // 0x8 and 0x9 fall through every range check and are illegal.
   function automatic op_class_t classify(input logic [3:0] opc);
      if (opc == OPC_MOV)                             return CLS_MOV;
      if (opc == OPC_MOVI)                            return CLS_MOVI;
      if ((opc >= OPC_ALU_LO) && (opc <= OPC_ALU_HI)) return CLS_ALU;
      if (opc >= OPC_ALUI_LO)                         return CLS_ALUI;
      return CLS_ILLEGAL;
   endfunction

endpackage

// File: rtl/instr_dispatch_if.sv
// instr_dispatch_if: handshake / unit-control bundle of the dispatcher.
//   master : instruction source and execution units (drives run, instr_valid,
//            instr, done_*; observes everything else)
//   slave  : the dispatcher (instr_dispatch)
interface instr_dispatch_if;
   import dispatch_pkg::*;

   logic               run;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic               instr_ready;
   logic [3:0]         op_code;
   logic [5:0]         op_ri;
   logic [5:0]         op_rj;
   logic               start_mov;
   logic               start_movi;
   logic               start_alu;
   logic               start_alui;
   logic               done_mov;
   logic               done_movi;
   logic               done_alu;
   logic               done_alui;
   logic               busy;
   logic               retire;
   logic               illegal;
   logic               timeout;
   logic [15:0]        retired_count;

   modport master (
      output run, instr_valid, instr, done_mov, done_movi, done_alu, done_alui,
      input  instr_ready, op_code, op_ri, op_rj,
             start_mov, start_movi, start_alu, start_alui,
             busy, retire, illegal, timeout, retired_count
   );

   modport slave (
      input  run, instr_valid, instr, done_mov, done_movi, done_alu, done_alui,
      output instr_ready, op_code, op_ri, op_rj,
             start_mov, start_movi, start_alu, start_alui,
             busy, retire, illegal, timeout, retired_count
   );

endinterface

// File: rtl/dispatch_wdog.sv
// dispatch_wdog: WAIT-state watchdog counter (built only with DISPATCH_TIMEOUT_EN).
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear (asserted the cycle before WAIT is entered)
//   enable     : count one per cycle (asserted while in WAIT)
//   terminal   : count has reached TIMEOUT_CYCLES-1
module dispatch_wdog
   import dispatch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       count_q <= '0;
      else if (clear)  count_q <= '0;
      else if (enable) count_q <= count_q + 1'b1;
   end

   assign terminal = (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_dispatch.sv
// instr_dispatch: single-issue instruction dispatcher.
//   Accepts one 16-bit instruction when idle and run=1, decodes the opcode
//   class, pulses the matching unit start for one cycle, waits for that unit's
//   done, then pulses retire and bumps retired_count.
//   Ports: clk, reset (async, active-high), bus (instr_dispatch_if.slave).
//   Parameter TIMEOUT_CYCLES: WAIT cycles before abort (watchdog build only).
//   Macro DISPATCH_TIMEOUT_EN: enables the WAIT watchdog; without it WAIT
//   waits indefinitely and timeout is tied low.
module instr_dispatch
   import dispatch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   instr_dispatch_if.slave  bus
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("instr_dispatch: TIMEOUT_CYCLES must be at least 1");
   end

   state_t      state;
   op_class_t   sel_q;
   op_class_t   dec_class;
   logic [3:0]  op_code_q;
   logic [5:0]  op_ri_q;
   logic [5:0]  op_rj_q;
   logic        start_mov_q, start_movi_q, start_alu_q, start_alui_q;
   logic        busy_q, retire_q, illegal_q;
   logic [15:0] count_q;
   logic        accept;
   logic        done_sel;

   assign dec_class = classify(op_code_q);

   // Combinational so a waiting instruction is taken in the first IDLE cycle.
   assign bus.instr_ready = (state == S_IDLE) && bus.run && !reset;
   assign accept          = bus.instr_valid && bus.instr_ready;

   always_comb begin
      done_sel = 1'b0;
      case (sel_q)
         CLS_MOV:  done_sel = bus.done_mov;
         CLS_MOVI: done_sel = bus.done_movi;
         CLS_ALU:  done_sel = bus.done_alu;
         CLS_ALUI: done_sel = bus.done_alui;
         default:  done_sel = 1'b0;
      endcase
   end

`ifdef DISPATCH_TIMEOUT_EN
   logic wdog_term;
   logic timeout_q;

   dispatch_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk      (clk),
      .reset    (reset),
      .clear    (state == S_ISSUE),
      .enable   (state == S_WAIT),
      .terminal (wdog_term)
   );

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         sel_q        <= CLS_ILLEGAL;
         op_code_q    <= '0;
         op_ri_q      <= '0;
         op_rj_q      <= '0;
         start_mov_q  <= 1'b0;
         start_movi_q <= 1'b0;
         start_alu_q  <= 1'b0;
         start_alui_q <= 1'b0;
         busy_q       <= 1'b0;
         retire_q     <= 1'b0;
         illegal_q    <= 1'b0;
         count_q      <= '0;
`ifdef DISPATCH_TIMEOUT_EN
         timeout_q    <= 1'b0;
`endif
      end else begin
         // All pulse outputs are high for exactly the one cycle after they are set.
         start_mov_q  <= 1'b0;
         start_movi_q <= 1'b0;
         start_alu_q  <= 1'b0;
         start_alui_q <= 1'b0;
         retire_q     <= 1'b0;
         illegal_q    <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
         timeout_q    <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_code_q <= bus.instr[OPC_MSB:OPC_LSB];
                  op_ri_q   <= bus.instr[RI_MSB:RI_LSB];
                  op_rj_q   <= bus.instr[RJ_MSB:RJ_LSB];
                  busy_q    <= 1'b1;
                  state     <= S_DECODE;
               end
            end
            S_DECODE: begin
               sel_q <= dec_class;
               if (dec_class == CLS_ILLEGAL) begin
                  retire_q  <= 1'b1;
                  illegal_q <= 1'b1;
                  count_q   <= count_q + 16'd1;
                  state     <= S_RETIRE;
               end else begin
                  start_mov_q  <= (dec_class == CLS_MOV);
                  start_movi_q <= (dec_class == CLS_MOVI);
                  start_alu_q  <= (dec_class == CLS_ALU);
                  start_alui_q <= (dec_class == CLS_ALUI);
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               // done has priority: done on the terminal cycle retires normally.
               if (done_sel) begin
                  retire_q <= 1'b1;
                  count_q  <= count_q + 16'd1;
                  state    <= S_RETIRE;
               end
`ifdef DISPATCH_TIMEOUT_EN
               else if (wdog_term) begin
                  retire_q  <= 1'b1;
                  timeout_q <= 1'b1;
                  count_q   <= count_q + 16'd1;
                  state     <= S_RETIRE;
               end
`endif
            end
            S_RETIRE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.op_code       = op_code_q;
   assign bus.op_ri         = op_ri_q;
   assign bus.op_rj         = op_rj_q;
   assign bus.start_mov     = start_mov_q;
   assign bus.start_movi    = start_movi_q;
   assign bus.start_alu     = start_alu_q;
   assign bus.start_alui    = start_alui_q;
   assign bus.busy          = busy_q;
   assign bus.retire        = retire_q;
   assign bus.illegal       = illegal_q;
   assign bus.retired_count = count_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// tb_instr_dispatch: scoreboard bench for instr_dispatch.
//   The driver plans each instruction from the opcode-class rules and the
//   chosen done delay, pushing expected start/retire events into queues; a
//   negedge monitor pops and compares whenever the DUT pulses start_* or retire.
`timescale 1ns/1ps
module tb_instr_dispatch;

`ifdef DISPATCH_TIMEOUT_EN
   localparam int unsigned TMO    = 8;
   localparam bit          TMO_EN = 1'b1;
`else
   localparam int unsigned TMO    = 16;
   localparam bit          TMO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instr_dispatch_if bus();

   instr_dispatch #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int unsigned cyc;
      logic [3:0]  units;   // {mov, movi, alu, alui}
   } start_exp_t;

   typedef struct {
      int unsigned cyc;
      logic        ill;
      logic        tmo;
      logic [15:0] cnt;
      logic [15:0] word;
   } ret_exp_t;

   start_exp_t  sq[$];
   ret_exp_t    rq[$];
   int unsigned cyc       = 0;
   int unsigned n_cmp     = 0;
   int unsigned n_bad     = 0;
   int unsigned exp_count = 0;
   logic        exp_busy  = 1'b0;
   logic        exp_ready = 1'b0;
   logic        mon_en    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Opcode class from the ISA table: 0 MOV, 1 MOVI, 2..7 ALU, 10..15 ALUI, else illegal (4).
   function automatic int unsigned ref_unit(input logic [15:0] w);
      int unsigned op;
      op = 32'(w[15:12]);
      if (op == 0) return 0;
      if (op == 1) return 1;
      if (op >= 2 && op <= 7) return 2;
      if (op >= 10) return 3;
      return 4;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   logic [3:0] mon_st;
   start_exp_t mon_se;
   ret_exp_t   mon_re;

   always @(negedge clk) begin
      if (mon_en) begin
         check("busy", 32'(bus.busy), 32'(exp_busy));
         check("instr_ready", 32'(bus.instr_ready), 32'(exp_ready));
         while (sq.size() > 0 && sq[0].cyc < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL start_missing: no start pulse, expected units 0x%0h at cycle %0d", sq[0].units, sq[0].cyc);
            void'(sq.pop_front());
         end
         while (rq.size() > 0 && rq[0].cyc < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL retire_missing: no retire pulse, expected at cycle %0d", rq[0].cyc);
            void'(rq.pop_front());
         end
         mon_st = {bus.start_mov, bus.start_movi, bus.start_alu, bus.start_alui};
         if (mon_st != 4'b0000) begin
            if (sq.size() == 0) check("start_unexpected", 32'(mon_st), 32'h0);
            else begin
               mon_se = sq.pop_front();
               check("start_cycle", cyc, mon_se.cyc);
               check("start_unit", 32'(mon_st), 32'(mon_se.units));
            end
         end
         if (bus.retire) begin
            if (rq.size() == 0) check("retire_unexpected", 32'(bus.retire), 32'h0);
            else begin
               mon_re = rq.pop_front();
               check("retire_cycle", cyc, mon_re.cyc);
               check("illegal", 32'(bus.illegal), 32'(mon_re.ill));
               check("timeout", 32'(bus.timeout), 32'(mon_re.tmo));
               check("retired_count", 32'(bus.retired_count), 32'(mon_re.cnt));
               check("op_code", 32'(bus.op_code), 32'(mon_re.word[15:12]));
               check("op_ri", 32'(bus.op_ri), 32'(mon_re.word[11:6]));
               check("op_rj", 32'(bus.op_rj), 32'(mon_re.word[5:0]));
            end
         end else begin
            check("illegal_without_retire", 32'(bus.illegal), 32'h0);
            check("timeout_without_retire", 32'(bus.timeout), 32'h0);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Random done lines; the selected unit's line is forced to sel_hi.
   task automatic set_dones(input int unsigned sel, input bit noisy, input bit sel_hi);
      logic [3:0] r;
      logic [3:0] mask;
      r    = noisy ? 4'hF : 4'($urandom);
      mask = (sel < 4) ? (4'b1000 >> sel) : 4'b0000;
      r    = (r & ~mask) | (sel_hi ? mask : 4'b0000);
      {bus.done_mov, bus.done_movi, bus.done_alu, bus.done_alui} = r;
   endtask

   task automatic idle_inputs();
      bus.run         = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = 16'($urandom);
      set_dones(4, 1'b0, 1'b0);
      exp_busy  = 1'b0;
      exp_ready = 1'b1;
   endtask

   // Offer w in the current (idle) cycle; done d cycles after WAIT entry;
   // then gap idle cycles with no acceptance possible.
   task automatic run_instr(input logic [15:0] w, input int unsigned d,
                            input int unsigned gap, input bit noisy);
      int unsigned a, u, r, dcyc;
      bit          tmo;
      start_exp_t  se;
      ret_exp_t    re;
      a = cyc;
      u = ref_unit(w);
      bus.run = 1'b1; bus.instr_valid = 1'b1; bus.instr = w;
      set_dones(4, 1'b0, 1'b0);
      exp_busy = 1'b0; exp_ready = 1'b1;
      tmo  = 1'b0;
      dcyc = a + 3 + d;
      if (u == 4)                    r = a + 2;
      else if (TMO_EN && d >= TMO) begin tmo = 1'b1; r = a + 3 + TMO; end
      else                           r = a + 4 + d;
      if (u < 4) begin
         se.cyc = a + 2; se.units = 4'b1000 >> u;
         sq.push_back(se);
      end
      exp_count = (exp_count + 1) % 65536;
      re.cyc = r; re.ill = (u == 4); re.tmo = tmo; re.cnt = 16'(exp_count); re.word = w;
      rq.push_back(re);
      for (int unsigned c = a + 1; c <= r; c++) begin
         step();
         bus.run         = 1'($urandom);
         bus.instr_valid = 1'($urandom);
         bus.instr       = 16'($urandom);
         set_dones(u, noisy, (u < 4) && !tmo && (cyc == dcyc));
         exp_busy = 1'b1; exp_ready = 1'b0;
      end
      for (int unsigned g = 0; g < gap; g++) begin
         step();
         if ($urandom % 2 == 0) begin bus.run = 1'b0; bus.instr_valid = 1'($urandom); end
         else                   begin bus.run = 1'b1; bus.instr_valid = 1'b0; end
         bus.instr = 16'($urandom);
         set_dones(4, 1'b0, 1'b0);
         exp_busy = 1'b0; exp_ready = bus.run;
      end
      step();
   endtask

   initial begin
      int unsigned a;
      start_exp_t  se;
      bus.run = 1'b1; bus.instr_valid = 1'b1; bus.instr = 16'h1234;
      set_dones(4, 1'b1, 1'b0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_instr_ready", 32'(bus.instr_ready), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_starts", 32'({bus.start_mov, bus.start_movi, bus.start_alu, bus.start_alui}), 32'h0);
      check("rst_retire", 32'({bus.retire, bus.illegal, bus.timeout}), 32'h0);
      check("rst_ops", 32'({bus.op_code, bus.op_ri, bus.op_rj}), 32'h0);
      check("rst_count", 32'(bus.retired_count), 32'h0);
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
      step();
      idle_inputs();
      mon_en = 1'b1;

      run_instr(16'h7045, 2, 0, 1'b0);   // class ALU (opcode 7), Ri=1, Rj=5
      run_instr(16'h8000, 0, 1, 1'b0);   // illegal
      run_instr(16'h0042, 3, 0, 1'b1);   // MOV with other done lines held high
      run_instr(16'h9FFF, 0, 0, 1'b0);   // illegal
      run_instr(16'h1ABC, 0, 0, 1'b0);   // MOVI, minimum latency
      run_instr(16'hF00F, 1, 2, 1'b1);   // ALUI
      if (TMO_EN) begin
         run_instr(16'h3111, TMO - 1, 0, 1'b0);   // done on the terminal cycle
         run_instr(16'hA222, TMO, 0, 1'b0);       // just too late: timeout
         run_instr(16'h4333, TMO + 4, 1, 1'b1);   // never done: timeout
      end
      for (int i = 0; i < 150; i++)
         run_instr(16'($urandom), $urandom_range(TMO_EN ? 10 : 6, 0),
                   ($urandom % 3 == 0) ? $urandom_range(3, 1) : 0, ($urandom % 4) == 0);

      // Counter wrap: preset to 0xFFFF while idle.
      idle_inputs();
      force dut.count_q = 16'hFFFF;
      step();
      idle_inputs();
      release dut.count_q;
      exp_count = 65535;
      run_instr(16'h2001, 1, 0, 1'b0);
      run_instr(16'h8001, 0, 0, 1'b0);

      // Reset while waiting on a unit.
      a = cyc;
      bus.run = 1'b1; bus.instr_valid = 1'b1; bus.instr = 16'h2ABC;
      set_dones(4, 1'b0, 1'b0);
      exp_busy = 1'b0; exp_ready = 1'b1;
      se.cyc = a + 2; se.units = 4'b0010;
      sq.push_back(se);
      for (int k = 0; k < 4; k++) begin
         step();
         bus.instr_valid = 1'b0;
         set_dones(2, 1'b0, 1'b0);
         exp_busy = 1'b1; exp_ready = 1'b0;
      end
      #2;
      mon_en = 1'b0;
      reset  = 1'b1;
      #1;
      check("wait_rst_busy", 32'(bus.busy), 32'h0);
      check("wait_rst_starts", 32'({bus.start_mov, bus.start_movi, bus.start_alu, bus.start_alui}), 32'h0);
      check("wait_rst_retire", 32'(bus.retire), 32'h0);
      check("wait_rst_count", 32'(bus.retired_count), 32'h0);
      check("wait_rst_ready", 32'(bus.instr_ready), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      exp_count = 0;
      step();
      idle_inputs();
      mon_en = 1'b1;
      run_instr(16'hB00C, 0, 0, 1'b0);
      run_instr(16'h0123, 2, 0, 1'b1);

      idle_inputs();
      repeat (4) step();
      mon_en = 1'b0;
      check("start_queue_drained", 32'(sq.size()), 32'h0);
      check("retire_queue_drained", 32'(rq.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
